dcache_store_write_buffer: RTL

Responder for the store-commit write port of the load/store unit interface: accepts retired-store writes (`dcWriteReq`, address, line data, byte enables, uncachable flag), acknowledges them, and holds them in a small FIFO of line-sized entries. Cachable writes to the same line as the youngest undrained entry are merged into it. Entries drain in order to the downstream memory/cache fill port over a valid/ready handshake. It sits between the store committer and the data cache array/memory interface, decoupling store commit from write latency.

---
 rtl/dcache_store_write_buffer_if.sv | 34 +++
 rtl/dcache_store_write_buffer.sv | 85 ++++++++
 2 files changed

// File: rtl/dcache_store_write_buffer_if.sv
// Store-commit write port and downstream memory request port of the store write buffer.
// The slave modport is the buffer's view; master is the view of the surrounding environment.
interface dcache_store_write_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES = 8
);
  logic                      dcWriteReq;
  logic [ADDR_WIDTH-1:0]     dcWriteAddr;
  logic [8*LINE_BYTES-1:0]   dcWriteData;
  logic [LINE_BYTES-1:0]     dcWriteByteWE;
  logic                      dcWriteUncachable;
  logic                      dcWriteReqAck;
  logic                      dcWriteBusy;
  logic                      dcWriteHit;
  logic                      memReqValid;
  logic [ADDR_WIDTH-1:0]     memReqAddr;
  logic [8*LINE_BYTES-1:0]   memReqData;
  logic [LINE_BYTES-1:0]     memReqByteWE;
  logic                      memReqUncachable;
  logic                      memReqReady;
  logic                      bufferEmpty;

  modport slave (
    input  dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE, dcWriteUncachable, memReqReady,
    output dcWriteReqAck, dcWriteBusy, dcWriteHit, memReqValid, memReqAddr, memReqData,
           memReqByteWE, memReqUncachable, bufferEmpty
  );

  modport master (
    output dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE, dcWriteUncachable, memReqReady,
    input  dcWriteReqAck, dcWriteBusy, dcWriteHit, memReqValid, memReqAddr, memReqData,
           memReqByteWE, memReqUncachable, bufferEmpty
  );
endinterface

// File: rtl/dcache_store_write_buffer.sv
// In-order FIFO of line-sized store entries; cachable stores to the youngest entry's line merge
// into it, and entries drain to memory over a valid/ready handshake.
module dcache_store_write_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES = 8
) (
  input logic                          clk,
  input logic                          rst,
  dcache_store_write_buffer_if.slave   bus
);
  localparam int unsigned OFFSET = $clog2(LINE_BYTES);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned DATA_W = 8 * LINE_BYTES;

  logic [ADDR_WIDTH-1:0] line_addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q      [DEPTH];
  logic [LINE_BYTES-1:0] byte_we_q   [DEPTH];
  logic                  unc_q       [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, young;
  logic [PTR_W:0]        count_q, count_d;
  logic                  hit_q;
  logic                  busy, ack, pop, merge, alloc, young_popping;
  logic [ADDR_WIDTH-1:0] req_line;
  logic                  unused_offset;

  assign unused_offset = ^bus.dcWriteAddr[OFFSET-1:0];
  assign req_line      = {bus.dcWriteAddr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};

  always_comb begin
    busy  = (count_q == (PTR_W+1)'(DEPTH));
    ack   = bus.dcWriteReq & ~busy;
    pop   = (count_q != '0) & bus.memReqReady;
    young = tail_q - PTR_W'(1);
    // With one entry left and it popping, merging would write a slot that is leaving.
    young_popping = (count_q == (PTR_W+1)'(1)) & pop;
    merge = ack & (count_q != '0) & ~bus.dcWriteUncachable & ~unc_q[young]
          & (line_addr_q[young] == req_line) & ~young_popping;
    alloc = ack & ~merge;

    head_d  = pop   ? head_q + PTR_W'(1) : head_q;
    tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
  end

  assign bus.dcWriteReqAck    = ack;
  assign bus.dcWriteBusy      = busy;
  assign bus.dcWriteHit       = hit_q;
  assign bus.bufferEmpty      = (count_q == '0);
  assign bus.memReqValid      = (count_q != '0);
  assign bus.memReqAddr       = line_addr_q[head_q];
  assign bus.memReqData       = data_q[head_q];
  assign bus.memReqByteWE     = byte_we_q[head_q];
  assign bus.memReqUncachable = unc_q[head_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      hit_q   <= merge;
    end
  end

  // Entry payload carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      line_addr_q[tail_q] <= req_line;
      data_q[tail_q]      <= bus.dcWriteData;
      byte_we_q[tail_q]   <= bus.dcWriteByteWE;
      unc_q[tail_q]       <= bus.dcWriteUncachable;
    end else if (merge) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (bus.dcWriteByteWE[b]) data_q[young][8*b +: 8] <= bus.dcWriteData[8*b +: 8];
      end
      byte_we_q[young] <= byte_we_q[young] | bus.dcWriteByteWE;
    end
  end
endmodule
